// File: rtl/rgmii_rx_decoder_pkg.sv
// rtl/rgmii_rx_decoder_pkg.sv - shared types and constants for the RGMII receive decoder
package rgmii_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DISCARD
  } rx_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

endpackage

// File: rtl/rgmii_rx_decoder_if.sv
// rtl/rgmii_rx_decoder_if.sv - beat input, byte stream output and link status bundle
interface rgmii_rx_decoder_if #(
  parameter int LEN_W = 16
) ();

  logic             in_valid;
  logic [7:0]       in_data;
  logic [1:0]       in_ctl;

  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_sof;
  logic             out_eof;
  logic             out_err;
  logic [LEN_W-1:0] frame_len;

  logic             link_up;
  logic             link_10mb;
  logic             link_100mb;
  logic             link_1000mb;
  logic             link_full_duplex;

  modport master (
    output in_valid, in_data, in_ctl,
    input  out_data, out_valid, out_sof, out_eof, out_err, frame_len,
    input  link_up, link_10mb, link_100mb, link_1000mb, link_full_duplex
  );

  modport slave (
    input  in_valid, in_data, in_ctl,
    output out_data, out_valid, out_sof, out_eof, out_err, frame_len,
    output link_up, link_10mb, link_100mb, link_1000mb, link_full_duplex
  );

endinterface

// File: rtl/rgmii_rx_decoder_inband.sv
// rtl/rgmii_rx_decoder_inband.sv - debounced in-band link status from inter-frame idle codes
module rgmii_inband_status
  import rgmii_rx_pkg::*;
#(
  parameter int LINK_STABLE = 4
) (
  input  logic       clk125MHz,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic [1:0] in_ctl,
  output logic       link_up,
  output logic       link_10mb,
  output logic       link_100mb,
  output logic       link_1000mb,
  output logic       link_full_duplex
);

  logic [3:0] last_code;
  logic [7:0] stable_cnt;
  logic       candidate;
  logic [3:0] code;
  logic [7:0] cnt_next;

  // An idle beat whose two nibbles agree carries a status code; count repeats of it.
  always_comb begin
    candidate = in_valid && (in_ctl == 2'b00) && (in_data[3:0] == in_data[7:4]);
    code      = in_data[3:0];
    cnt_next  = 8'd1;
    if (code == last_code) begin
      cnt_next = (stable_cnt >= 8'(LINK_STABLE)) ? stable_cnt : stable_cnt + 8'd1;
    end
  end

  // Track the candidate code and publish it once it has been seen LINK_STABLE times in a row.
  always_ff @(posedge clk125MHz or posedge rst) begin
    if (rst) begin
      last_code        <= 4'h0;
      stable_cnt       <= 8'd0;
      link_up          <= 1'b0;
      link_10mb        <= 1'b0;
      link_100mb       <= 1'b0;
      link_1000mb      <= 1'b0;
      link_full_duplex <= 1'b0;
    end else if (candidate) begin
      last_code  <= code;
      stable_cnt <= cnt_next;
      if (cnt_next == 8'(LINK_STABLE)) begin
        link_up          <= code[0];
        link_10mb        <= code[0] && (code[2:1] == SPEED_10);
        link_100mb       <= code[0] && (code[2:1] == SPEED_100);
        link_1000mb      <= code[0] && (code[2:1] == SPEED_1000);
        link_full_duplex <= code[0] && code[3];
      end
    end
  end

endmodule

// File: rtl/rgmii_rx_decoder.sv
// rtl/rgmii_rx_decoder.sv - RGMII beat to byte-stream decoder with framing, errors and length
module rgmii_rx_decoder
  import rgmii_rx_pkg::*;
#(
  parameter int LINK_STABLE    = 4,
  parameter int STRIP_PREAMBLE = 1,
  parameter int MAX_PREAMBLE   = 7,
  parameter int MAX_FRAME      = 1522,
  parameter int LEN_W          = 16
) (
  input logic               clk125MHz,
  input logic               rst,
  rgmii_rx_decoder_if.slave rx
);

  rx_state_t        state;
  rx_state_t        pre_state;
  logic             nib_mode;
  logic             nib_phase;
  logic [3:0]       low_nib;
  logic [7:0]       hold_byte;
  logic             hold_valid;
  logic             sof_pending;
  logic             err_flag;
  logic [LEN_W-1:0] len_cnt;
  logic [LEN_W-1:0] len_inc;
  logic [7:0]       pre_cnt;
  logic [7:0]       pre_next;
  logic             dv;
  logic             er;
  logic             mode_now;
  logic             phase_now;
  logic             byte_done;
  logic [7:0]       byte_val;
  logic             st_up, st_10, st_100, st_1000, st_fd;

  rgmii_inband_status #(.LINK_STABLE(LINK_STABLE)) u_inband (
    .clk125MHz        (clk125MHz),
    .rst              (rst),
    .in_valid         (rx.in_valid),
    .in_data          (rx.in_data),
    .in_ctl           (rx.in_ctl),
    .link_up          (st_up),
    .link_10mb        (st_10),
    .link_100mb       (st_100),
    .link_1000mb      (st_1000),
    .link_full_duplex (st_fd)
  );

  assign rx.link_up          = st_up;
  assign rx.link_10mb        = st_10;
  assign rx.link_100mb       = st_100;
  assign rx.link_1000mb      = st_1000;
  assign rx.link_full_duplex = st_fd;

  // Beat decode and byte assembly; the first beat of a frame uses the live link speed.
  always_comb begin
    dv        = rx.in_ctl[0];
    er        = rx.in_ctl[0] ^ rx.in_ctl[1];
    mode_now  = (state == ST_IDLE) ? (st_10 | st_100) : nib_mode;
    phase_now = (state == ST_IDLE) ? 1'b0 : nib_phase;
    if (mode_now) begin
      byte_done = dv && phase_now;
      byte_val  = {rx.in_data[3:0], low_nib};
    end else begin
      byte_done = dv;
      byte_val  = rx.in_data;
    end
    len_inc   = (len_cnt == '1) ? len_cnt : len_cnt + LEN_W'(1);
    pre_next  = ((state == ST_IDLE) ? 8'd0 : pre_cnt) + 8'd1;
    pre_state = ST_PREAMBLE;
    if (byte_done) begin
      if (byte_val == SFD_BYTE) begin
        pre_state = ST_DATA;
      end else if (byte_val != PREAMBLE_BYTE || pre_next > 8'(MAX_PREAMBLE)) begin
        pre_state = ST_DISCARD;
      end
    end
  end

  // Frame FSM: strips preamble, delays bytes by one through the hold register, flags errors.
  always_ff @(posedge clk125MHz or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      nib_mode     <= 1'b0;
      nib_phase    <= 1'b0;
      low_nib      <= 4'h0;
      hold_byte    <= 8'h00;
      hold_valid   <= 1'b0;
      sof_pending  <= 1'b0;
      err_flag     <= 1'b0;
      len_cnt      <= '0;
      pre_cnt      <= 8'd0;
      rx.out_data  <= 8'h00;
      rx.out_valid <= 1'b0;
      rx.out_sof   <= 1'b0;
      rx.out_eof   <= 1'b0;
      rx.out_err   <= 1'b0;
      rx.frame_len <= '0;
    end else begin
      rx.out_valid <= 1'b0;
      rx.out_sof   <= 1'b0;
      rx.out_eof   <= 1'b0;
      rx.out_err   <= 1'b0;
      if (rx.in_valid) begin
        if (dv && mode_now) begin
          if (!phase_now) low_nib <= rx.in_data[3:0];
          nib_phase <= ~phase_now;
        end
        case (state)
          ST_IDLE: begin
            if (dv) begin
              nib_mode    <= mode_now;
              sof_pending <= 1'b1;
              len_cnt     <= '0;
              pre_cnt     <= 8'd0;
              hold_valid  <= 1'b0;
              err_flag    <= 1'b0;
              if (STRIP_PREAMBLE != 0) begin
                state <= pre_state;
                if (byte_done) pre_cnt <= pre_next;
              end else begin
                state      <= ST_DATA;
                err_flag   <= er;
                hold_byte  <= byte_val;
                hold_valid <= byte_done;
              end
            end
          end
          ST_PREAMBLE: begin
            if (!dv) begin
              state <= ST_IDLE;
            end else begin
              state <= pre_state;
              if (byte_done) pre_cnt <= pre_next;
            end
          end
          ST_DATA: begin
            if (er) err_flag <= 1'b1;
            if (dv) begin
              if (byte_done) begin
                hold_byte  <= byte_val;
                hold_valid <= 1'b1;
                if (hold_valid) begin
                  rx.out_data  <= hold_byte;
                  rx.out_valid <= 1'b1;
                  rx.out_sof   <= sof_pending;
                  sof_pending  <= 1'b0;
                  len_cnt      <= len_inc;
                end
              end
            end else begin
              if (hold_valid) begin
                rx.out_data  <= hold_byte;
                rx.out_valid <= 1'b1;
                rx.out_sof   <= sof_pending;
                rx.out_eof   <= 1'b1;
                rx.out_err   <= err_flag | er | (nib_mode & nib_phase) |
                                (32'(len_inc) > 32'(MAX_FRAME));
                rx.frame_len <= len_inc;
              end
              sof_pending <= 1'b0;
              hold_valid  <= 1'b0;
              state       <= ST_IDLE;
            end
          end
          ST_DISCARD: begin
            if (!dv) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// tb/tb_rgmii_rx_decoder.sv - scoreboard bench for rgmii_rx_decoder
module tb_rgmii_rx_decoder;

  typedef struct packed {
    logic [7:0]  d;
    logic        sof;
    logic        eof;
    logic        err;
    logic [15:0] len;
  } rec_t;

  logic clk125MHz = 1'b0;
  logic rst       = 1'b1;

  always #4 clk125MHz = ~clk125MHz;

  rgmii_rx_decoder_if #(.LEN_W(16)) rx ();

  rgmii_rx_decoder #(
    .LINK_STABLE    (4),
    .STRIP_PREAMBLE (1),
    .MAX_PREAMBLE   (7),
    .MAX_FRAME      (1522),
    .LEN_W          (16)
  ) dut (
    .clk125MHz (clk125MHz),
    .rst       (rst),
    .rx        (rx)
  );

  rec_t       exp_q[$];
  rec_t       obs_q[$];
  logic [7:0] payload[$];
  int         n_vec = 0;
  int         n_err = 0;

  // Capture every emitted byte, away from the active edge.
  always @(negedge clk125MHz) begin
    rec_t r;
    if (rx.out_valid === 1'b1) begin
      r.d   = rx.out_data;
      r.sof = rx.out_sof;
      r.eof = rx.out_eof;
      r.err = rx.out_err;
      r.len = rx.out_eof ? rx.frame_len : 16'h0;
      obs_q.push_back(r);
    end
  end

  task automatic beat(input logic v, input logic [7:0] d, input logic [1:0] c);
    @(negedge clk125MHz);
    rx.in_valid = v;
    rx.in_data  = d;
    rx.in_ctl   = c;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 8'h00, 2'b00);
  endtask

  task automatic send_byte(input bit nib, input logic [7:0] b, input bit er);
    if (nib) begin
      beat(1'b1, {b[3:0], b[3:0]}, er ? 2'b01 : 2'b11);
      beat(1'b1, {b[7:4], b[7:4]}, 2'b11);
    end else begin
      beat(1'b1, b, er ? 2'b01 : 2'b11);
    end
  endtask

  task automatic send_preamble(input bit nib);
    for (int i = 0; i < 7; i++) send_byte(nib, 8'h55, 1'b0);
    send_byte(nib, 8'hD5, 1'b0);
  endtask

  task automatic send_frame(input bit nib, input int er_at, input bit exp_err);
    send_preamble(nib);
    for (int i = 0; i < payload.size(); i++) begin
      rec_t r;
      r.d   = payload[i];
      r.sof = (i == 0);
      r.eof = (i == payload.size() - 1);
      r.err = r.eof & exp_err;
      r.len = r.eof ? 16'(payload.size()) : 16'h0;
      exp_q.push_back(r);
      send_byte(nib, payload[i], i == er_at);
    end
    beat(1'b1, 8'h0F, 2'b00);
    idle(3);
  endtask

  task automatic test_reset();
    rx.in_valid = 1'b0;
    rx.in_data  = 8'h00;
    rx.in_ctl   = 2'b00;
    rst         = 1'b1;
    repeat (3) @(negedge clk125MHz);
    n_vec++;
    if ({rx.out_data, rx.out_valid, rx.out_sof, rx.out_eof, rx.out_err, rx.frame_len,
         rx.link_up, rx.link_10mb, rx.link_100mb, rx.link_1000mb, rx.link_full_duplex} !== 33'h0) begin
      n_err++;
      $display("FAIL reset_outputs got data=%h v=%b len=%0d link=%b want all zero",
               rx.out_data, rx.out_valid, rx.frame_len, rx.link_up);
    end
    rst = 1'b0;
  endtask

  task automatic test_link_status();
    logic [4:0] lk;
    repeat (3) beat(1'b1, 8'hDD, 2'b00);
    @(posedge clk125MHz); #1;
    n_vec++;
    if (rx.link_up !== 1'b0) begin
      n_err++;
      $display("FAIL link_after3 got link_up=%b want 0", rx.link_up);
    end
    beat(1'b1, 8'hDD, 2'b00);
    @(posedge clk125MHz); #1;
    lk = {rx.link_up, rx.link_10mb, rx.link_100mb, rx.link_1000mb, rx.link_full_duplex};
    n_vec++;
    if (lk !== 5'b10011) begin
      n_err++;
      $display("FAIL link_after4 got %b want 10011", lk);
    end
    beat(1'b1, 8'h33, 2'b00);
    @(posedge clk125MHz); #1;
    lk = {rx.link_up, rx.link_10mb, rx.link_100mb, rx.link_1000mb, rx.link_full_duplex};
    n_vec++;
    if (lk !== 5'b10011) begin
      n_err++;
      $display("FAIL link_single33 got %b want 10011", lk);
    end
    idle(2);
  endtask

  task automatic test_byte_frame();
    rec_t e, o;
    payload.delete();
    for (int i = 1; i <= 64; i++) payload.push_back(8'(i));
    send_frame(1'b0, -1, 1'b0);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL byte_frame_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL byte_frame_rec got %h want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_error_frame();
    rec_t e, o;
    payload.delete();
    for (int i = 0; i < 64; i++) payload.push_back(8'(8'h80 + i));
    send_frame(1'b0, 9, 1'b1);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL er_frame_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL er_frame_rec got %h want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_preamble_discard();
    rec_t e, o;
    beat(1'b1, 8'h55, 2'b11);
    beat(1'b1, 8'h55, 2'b11);
    beat(1'b1, 8'hAA, 2'b11);
    repeat (3) beat(1'b1, 8'h11, 2'b11);
    beat(1'b1, 8'h0F, 2'b00);
    idle(2);
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL discard_silent got %0d bytes want 0", obs_q.size());
    end
    obs_q.delete();
    payload.delete();
    payload.push_back(8'hA1);
    payload.push_back(8'hA2);
    payload.push_back(8'hA3);
    send_frame(1'b0, -1, 1'b0);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL after_discard_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL after_discard_rec got %h want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_short_frames();
    rec_t e, o;
    send_preamble(1'b0);
    beat(1'b1, 8'h0F, 2'b00);
    idle(3);
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL sfd_only got %0d bytes want 0", obs_q.size());
    end
    obs_q.delete();
    payload.delete();
    payload.push_back(8'h5A);
    send_frame(1'b0, -1, 1'b0);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL one_byte_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL one_byte_rec got %h want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_oversize();
    rec_t e, o;
    for (int n = 1522; n <= 1523; n++) begin
      payload.delete();
      for (int i = 0; i < n; i++) payload.push_back(8'(i));
      send_frame(1'b0, -1, n > 1522);
      n_vec++;
      if (obs_q.size() != exp_q.size()) begin
        n_err++;
        $display("FAIL oversize_count n=%0d got %0d want %0d", n, obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        n_vec++;
        if (o !== e) begin
          n_err++;
          $display("FAIL oversize_rec n=%0d got %h want %h", n, o, e);
        end
      end
      exp_q.delete();
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid_frame();
    rec_t e, o;
    rec_t r;
    send_preamble(1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i < 19) begin
        r.d   = 8'(8'h40 + i);
        r.sof = (i == 0);
        r.eof = 1'b0;
        r.err = 1'b0;
        r.len = 16'h0;
        exp_q.push_back(r);
      end
      send_byte(1'b0, 8'(8'h40 + i), 1'b0);
    end
    @(negedge clk125MHz);
    rst         = 1'b1;
    rx.in_valid = 1'b0;
    #1;
    n_vec++;
    if ({rx.out_data, rx.out_valid, rx.out_sof, rx.out_eof, rx.out_err, rx.frame_len,
         rx.link_up, rx.link_10mb, rx.link_100mb, rx.link_1000mb, rx.link_full_duplex} !== 33'h0) begin
      n_err++;
      $display("FAIL midrst_outputs got data=%h v=%b eof=%b len=%0d want all zero",
               rx.out_data, rx.out_valid, rx.out_eof, rx.frame_len);
    end
    @(negedge clk125MHz);
    rst = 1'b0;
    idle(2);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL midrst_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL midrst_rec got %h want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
    payload.delete();
    for (int i = 0; i < 5; i++) payload.push_back(8'(8'hC0 + i));
    send_frame(1'b0, -1, 1'b0);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL postrst_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL postrst_rec got %h want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_nibble_frame();
    rec_t e, o;
    rec_t r;
    logic [4:0] lk;
    repeat (4) beat(1'b1, 8'h33, 2'b00);
    idle(1);
    lk = {rx.link_up, rx.link_10mb, rx.link_100mb, rx.link_1000mb, rx.link_full_duplex};
    n_vec++;
    if (lk !== 5'b10100) begin
      n_err++;
      $display("FAIL link_100mb got %b want 10100", lk);
    end
    payload.delete();
    payload.push_back(8'h12);
    payload.push_back(8'h34);
    send_frame(1'b1, -1, 1'b0);
    send_preamble(1'b1);
    send_byte(1'b1, 8'h12, 1'b0);
    beat(1'b1, 8'h44, 2'b11);
    r.d   = 8'h12;
    r.sof = 1'b1;
    r.eof = 1'b1;
    r.err = 1'b1;
    r.len = 16'd1;
    exp_q.push_back(r);
    beat(1'b1, 8'h0F, 2'b00);
    idle(3);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL nibble_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL nibble_rec got %h want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_link_status();
    test_byte_frame();
    test_error_frame();
    test_preamble_discard();
    test_short_frames();
    test_oversize();
    test_reset_mid_frame();
    test_nibble_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
